// File: rtl/kbd_serial_bridge_if.sv
// Keyboard-side strobe bus plus serial four-phase request/acknowledge bus.
// The bridge connects through the slave modport; the environment uses master.
interface kbd_serial_bridge_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] k_data;
  logic              k_flag;
  logic              s_req;
  logic [DATA_W-1:0] s_data;
  logic              s_ack;

  modport slave (
    input  k_data,
    input  k_flag,
    input  s_ack,
    output s_req,
    output s_data
  );

  modport master (
    output k_data,
    output k_flag,
    output s_ack,
    input  s_req,
    input  s_data
  );
endinterface

// File: rtl/kbd_serial_bridge.sv
// Buffers keyboard words in a FIFO and forwards each one over a four-phase
// request/acknowledge link, with an optional acknowledge timeout and sticky error flags.
module kbd_serial_bridge #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  kbd_serial_bridge_if.slave         bus,
  input  logic                       clr_err,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  output logic                       timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam bit TMO_EN_C = (ACK_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  // Expiry fires on the edge where the counter would reach ACK_TIMEOUT.
  localparam logic [TMO_W-1:0] TMO_LAST_C = (ACK_TIMEOUT > 0) ? TMO_W'(ACK_TIMEOUT - 1) : {TMO_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK1 = 2'd1,
    WAIT_ACK0 = 2'd2
  } state_t;

  state_t            state_r;
  logic              s_req_r;
  logic [DATA_W-1:0] s_data_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              overflow_r;
  logic              timeout_err_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic pop_s;
  logic push_s;
  logic drop_s;
  logic expire_s;

  assign bus.s_req   = s_req_r;
  assign bus.s_data  = s_data_r;
  assign fifo_count  = count_r;
  assign overflow    = overflow_r;
  assign timeout_err = timeout_err_r;

  // Per-cycle FIFO and timeout decisions; a pop frees a slot for a same-cycle push.
  always_comb begin
    pop_s    = 1'b0;
    push_s   = 1'b0;
    drop_s   = 1'b0;
    expire_s = 1'b0;
    pop_s    = (state_r == IDLE) && (count_r != {CNT_W{1'b0}}) && !bus.s_ack;
    push_s   = bus.k_flag && ((count_r != FULL_C) || pop_s);
    drop_s   = bus.k_flag && !push_s;
    expire_s = TMO_EN_C && (state_r == WAIT_ACK1) && !bus.s_ack && (tmo_cnt_r == TMO_LAST_C);
  end

  // FIFO storage; contents need no reset because only counted entries are read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.k_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Four-phase handshake FSM with registered request, data and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      s_req_r   <= 1'b0;
      s_data_r  <= {DATA_W{1'b0}};
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            s_data_r  <= mem_r[rd_ptr_r];
            s_req_r   <= 1'b1;
            tmo_cnt_r <= {TMO_W{1'b0}};
            state_r   <= WAIT_ACK1;
          end else begin
            s_req_r <= 1'b0;
          end
        end
        WAIT_ACK1: begin
          if (bus.s_ack) begin
            s_req_r <= 1'b0;
            state_r <= WAIT_ACK0;
          end else if (expire_s) begin
            // Abandon the word; the responder must still return s_ack low.
            s_req_r   <= 1'b0;
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            state_r   <= WAIT_ACK0;
          end else if (TMO_EN_C) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end else begin
            tmo_cnt_r <= tmo_cnt_r;
          end
        end
        WAIT_ACK0: begin
          if (!bus.s_ack) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_ACK0;
          end
        end
        default: begin
          state_r <= IDLE;
          s_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a set event outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end
      if (expire_s) begin
        timeout_err_r <= 1'b1;
      end else if (clr_err) begin
        timeout_err_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kbd_serial_bridge.sv
// Directed bench for kbd_serial_bridge: a scoreboard queue holds words expected on the
// serial side, and a negedge monitor pops and compares them as s_req rises.
module tb_kbd_serial_bridge;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int TMO    = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_err;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       timeout_err;

  logic       manual_mode;
  logic       man_ack;
  logic       auto_ack = 1'b0;
  int         ack_dly;
  int         wcnt = 0;

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb[$];
  logic       prev_req = 1'b0;
  logic [7:0] held = 8'h00;

  kbd_serial_bridge_if #(.DATA_W(DATA_W)) bus ();

  kbd_serial_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_err    (clr_err),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign bus.s_ack = manual_mode ? man_ack : auto_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Auto responder: raises s_ack ack_dly cycles after s_req, drops it after s_req falls.
  always @(posedge clk) begin
    #1;
    if (manual_mode || !rst_n) begin
      auto_ack = 1'b0;
      wcnt = 0;
    end else if (bus.s_req && !auto_ack) begin
      if (wcnt >= ack_dly) auto_ack = 1'b1;
      else wcnt++;
    end else if (!bus.s_req) begin
      auto_ack = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor: each new request must carry the oldest expected word, held stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (bus.s_req && !prev_req) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_word", 32'(bus.s_data), 32'hFFFF_FFFF);
        end else begin
          check("sb_word_order", 32'(bus.s_data), 32'(sb.pop_front()));
        end
        held = bus.s_data;
      end else if (bus.s_req) begin
        check("s_data_stable", 32'(bus.s_data), 32'(held));
      end
      prev_req = bus.s_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit track);
    bus.k_data = d;
    bus.k_flag = 1'b1;
    if (track) sb.push_back(d);
    step();
    bus.k_flag = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (n < budget && (bus.s_req || auto_ack || fifo_count != 4'd0 || sb.size() != 0)) begin
      step();
      n++;
    end
    step();
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    check({tag, "_idle_req"}, 32'(bus.s_req), 32'd0);
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (n < budget && !bus.s_req) begin
      step();
      n++;
    end
    check({tag, "_req_seen"}, 32'(bus.s_req), 32'd1);
  endtask

  initial begin
    int peak;
    int hi;
    manual_mode = 1'b1;
    man_ack     = 1'b0;
    ack_dly     = 0;
    clr_err     = 1'b0;
    bus.k_flag  = 1'b0;
    bus.k_data  = 8'h00;

    // Reset values while rst_n is held low.
    #12;
    check("rst_s_req", 32'(bus.s_req), 32'd0);
    check("rst_s_data", 32'(bus.s_data), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    #11 rst_n = 1'b1;
    step();

    // Single word, one-cycle responder: s_req two edges after k_flag.
    manual_mode = 1'b0;
    ack_dly = 0;
    push(8'hA5, 1'b1);
    check("single_e0_req", 32'(bus.s_req), 32'd0);
    check("single_e0_count", 32'(fifo_count), 32'd1);
    step();
    check("single_e1_req", 32'(bus.s_req), 32'd1);
    check("single_e1_data", 32'(bus.s_data), 32'hA5);
    check("single_e1_count", 32'(fifo_count), 32'd0);
    step();
    check("single_e2_req", 32'(bus.s_req), 32'd0);
    wait_idle("single", 50);

    // Burst of 8 back-to-back words with a slow responder.
    ack_dly = 5;
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      push(8'(i + 1), 1'b1);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    check("burst_peak_7_or_8", 32'((peak == 7) || (peak == 8)), 32'd1);
    wait_idle("burst", 300);
    check("burst_overflow", 32'(overflow), 32'd0);

    // Overflow: s_ack held high keeps the FSM in IDLE so the FIFO fills.
    manual_mode = 1'b1;
    man_ack = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b1);
    check("ovf_full_count", 32'(fifo_count), 32'd8);
    check("ovf_full_req", 32'(bus.s_req), 32'd0);
    check("ovf_before_drop", 32'(overflow), 32'd0);
    push(8'hFF, 1'b0);
    check("ovf_flag_set", 32'(overflow), 32'd1);
    check("ovf_count_held", 32'(fifo_count), 32'd8);
    clr_err = 1'b1;
    push(8'hFF, 1'b0);
    clr_err = 1'b0;
    check("ovf_set_beats_clear", 32'(overflow), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("ovf_count_after_clr", 32'(fifo_count), 32'd8);

    // Full FIFO with a push in the pop cycle.
    man_ack = 1'b0;
    push(8'h77, 1'b1);
    check("fullpop_count", 32'(fifo_count), 32'd8);
    check("fullpop_overflow", 32'(overflow), 32'd0);
    check("fullpop_req", 32'(bus.s_req), 32'd1);
    manual_mode = 1'b0;
    ack_dly = 1;
    wait_idle("fullpop", 300);

    // Timeout with a silent responder; the next word follows once s_ack is low.
    manual_mode = 1'b1;
    man_ack = 1'b0;
    push(8'h3C, 1'b1);
    push(8'h4D, 1'b1);
    hi = bus.s_req ? 1 : 0;
    for (int n = 0; n < 40 && bus.s_req; n++) begin
      step();
      if (bus.s_req) hi++;
    end
    check("tmo_req_cycles", 32'(hi), 32'd16);
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    wait_req("tmo_next", 10);
    check("tmo_next_data", 32'(bus.s_data), 32'h4D);
    man_ack = 1'b1;
    step();
    check("tmo_next_acked", 32'(bus.s_req), 32'd0);
    man_ack = 1'b0;
    step();
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("tmo_err_cleared", 32'(timeout_err), 32'd0);

    // Acknowledge arriving in the expiry cycle wins over the timeout.
    push(8'h5E, 1'b1);
    step();
    check("prio_req_up", 32'(bus.s_req), 32'd1);
    repeat (15) step();
    check("prio_req_before_expiry", 32'(bus.s_req), 32'd1);
    man_ack = 1'b1;
    step();
    check("prio_req_dropped", 32'(bus.s_req), 32'd0);
    check("prio_no_timeout_err", 32'(timeout_err), 32'd0);
    man_ack = 1'b0;
    step();

    // Asynchronous reset in WAIT_ACK1 with three words buffered.
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), 1'b1);
    check("arst_pre_count", 32'(fifo_count), 32'd3);
    check("arst_pre_req", 32'(bus.s_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(bus.s_req), 32'd0);
    check("arst_count", 32'(fifo_count), 32'd0);
    check("arst_data", 32'(bus.s_data), 32'd0);
    sb.delete();
    #2;
    bus.k_data = 8'h99;
    bus.k_flag = 1'b1;
    sb.push_back(8'h99);
    rst_n = 1'b1;
    step();
    bus.k_flag = 1'b0;
    check("post_rst_first_edge_push", 32'(fifo_count), 32'd1);
    manual_mode = 1'b0;
    ack_dly = 0;
    wait_idle("post_rst", 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
